bf16_to_fp8_packer: RTL and testbench
=====================================

BF16_TO_FP8_PACKER -- requirements
Module: bf16_to_fp8_packer

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: in_data/in_last valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts input this cycle.
REQ-005 SHALL have port in_data, input, 16 bits: BF16 accumulator value (sign, 8-bit exp bias 127, 7-bit mant).
REQ-006 SHALL have port in_last, input, 1 bit: final value of a drain burst.
REQ-007 SHALL have port out_valid, output, 1 bit: out_data/out_keep valid.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts word.
REQ-009 SHALL have port out_data, output, 32 bits: four packed FP8 E4M3 lanes; lane k = bits [8k+7:8k].
REQ-010 SHALL have port out_keep, output, 4 bits: per-lane valid mask.
REQ-011 SHALL have port clear_flags, input, 1 bit: synchronous clear of sticky flags.
REQ-012 SHALL have ports ovf_flag, unf_flag, nan_flag, output, 1 bit each: sticky status.

Function
REQ-013 SHALL accept a value when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-014 SHALL convert BF16 to E4M3 (bias 7; exp 1111 = Inf/NaN; max finite 0x77 = 240; min subnormal 0x01 = 2^-9) combinationally at acceptance.
REQ-015 SHALL round to nearest, ties to even, using guard plus sticky over all discarded BF16 mantissa bits, including the subnormal range.
REQ-016 SHALL handle a mantissa carry-out from rounding by incrementing the exponent; carry from subnormal 0x07 yields normal 0x08.
REQ-017 SHALL produce, for finite magnitudes rounding to >= 256: 0x78 with sign (Inf) and set ovf_flag.
REQ-018 SHALL produce, for nonzero magnitudes rounding to zero: signed zero (0x00/0x80) and set unf_flag.
REQ-019 SHALL map BF16 Inf to signed 0x78, BF16 NaN to 0x7C (sign dropped) setting nan_flag, and BF16 zero or subnormal to signed zero without flags.
REQ-020 SHALL hold a lane counter 0..3 and a staging word; an accepted value writes lane[counter].
REQ-021 SHALL, when the accepted value fills lane 3 or has in_last=1, move staging to the output register on that edge: out_valid=1 next cycle, zero latency beyond one edge; counter returns to 0; staging clears.
REQ-022 SHALL zero unused lanes on an in_last flush and set out_keep to the low (counter+1) bits; a full word has out_keep=1111.
REQ-023 SHALL hold out_data/out_keep stable while out_valid && !out_ready; clear out_valid after a handshake unless a new word loads on the same edge.
REQ-024 SHALL keep sticky flags set until clear_flags; on the same-cycle set and clear, set wins.

Reset
REQ-025 SHALL on rst drive in all cases out_valid=0, out_data=0, out_keep=0, all flags 0, counter 0, staging 0.
REQ-026 SHALL discard a partially filled word and any pending output word on rst mid-burst; no output appears after release until new input.

Configuration
REQ-027 SHALL, with FP8_SAT_EN defined, saturate finite overflow to signed 0x77 (ovf_flag still set); Inf inputs still map to 0x78.
REQ-028 SHALL, without FP8_SAT_EN, behave per REQ-017.

Verification
REQ-029 SHALL cover: inputs 0x3F80, 0xC000, 0x4370, 0x3B00 back-to-back with out_ready=1 -> one word 0x0177C038, out_keep=1111, no flags.
REQ-030 SHALL cover: 0x3F80, then 0xC000 with in_last=1 -> 0x0000C038, out_keep=0011.
REQ-031 SHALL cover: 0x4378 (248, tie) -> lane 0x78 and ovf_flag=1; with FP8_SAT_EN -> 0x77 and ovf_flag=1.
REQ-032 SHALL cover: 0x3A80 (2^-10, tie to even) -> 0x00 and unf_flag=1; then 0x7FC0 -> 0x7C and nan_flag=1; clear_flags -> all flags 0.
REQ-033 SHALL cover: out_ready=0 with a full word pending -> in_ready=0 and out_data stable for 5 cycles; raising out_ready completes the handshake and in_ready returns to 1.
REQ-034 SHALL cover: rst asserted after 2 accepted values -> outputs 0; then 4 new values -> word contains only the new values.

Source files
------------

// File: rtl/bf16_to_fp8_packer_if.sv
// Streaming handshake bundle for the BF16 -> FP8 E4M3 packer.
// The master drives BF16 input values and the downstream ready; the slave is the packer.
interface bf16_to_fp8_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep
    );
endinterface

// File: rtl/bf16_to_fp8_packer.sv
// Converts BF16 values to FP8 E4M3 (RNE) and packs four lanes per 32-bit output word.
// Define FP8_SAT_EN to saturate finite overflow to +/-0x77 instead of producing Inf.
module bf16_to_fp8_packer (
    input  logic                 clk,
    input  logic                 rst,
    bf16_to_fp8_packer_if.slave  bus,
    input  logic                 clear_flags,
    output logic                 ovf_flag,
    output logic                 unf_flag,
    output logic                 nan_flag
);

    // Returns {ovf, unf, nan, e4m3_byte}.
    function automatic logic [10:0] convert(input logic [15:0] v);
        logic              s;
        logic [7:0]        e;
        logic [6:0]        m;
        logic signed [9:0] tgt_exp;
        logic [3:0]        sh;
        logic [15:0]       sig;
        logic [15:0]       mask;
        logic [4:0]        kept;
        logic [4:0]        kept_r;
        logic              guard;
        logic              sticky;
        logic [11:0]       code;
        logic [10:0]       res;
        s = v[15];
        e = v[14:7];
        m = v[6:0];
        tgt_exp = $signed({2'b00, e}) - 10'sd120;
        // Subnormal targets shift further right; past 10 every bit is sticky anyway.
        if (tgt_exp >= 10'sd1) begin
            sh = 4'd4;
        end else if (tgt_exp <= -10'sd5) begin
            sh = 4'd10;
        end else begin
            sh = 4'(10'sd5 - tgt_exp);
        end
        sig    = {8'd0, 1'b1, m};
        mask   = (16'd1 << (sh - 4'd1)) - 16'd1;
        guard  = sig[sh - 4'd1];
        sticky = |(sig & mask);
        kept   = 5'(sig >> sh);
        kept_r = kept + {4'd0, guard & (sticky | kept[0])};
        // Adding the rounded significand onto the exponent field absorbs any carry-out.
        if (tgt_exp >= 10'sd1) begin
            code = {tgt_exp[8:0] - 9'd1, 3'b000} + {7'd0, kept_r};
        end else begin
            code = {7'd0, kept_r};
        end
        res = {3'b000, s, 7'h00};
        if (e == 8'hFF) begin
            if (m != 7'd0) begin
                res = {3'b001, 8'h7C};
            end else begin
                res = {3'b000, s, 7'h78};
            end
        end else if (e != 8'h00) begin
            if (code >= 12'h078) begin
`ifdef FP8_SAT_EN
                res = {3'b100, s, 7'h77};
`else
                res = {3'b100, s, 7'h78};
`endif
            end else if (code == 12'd0) begin
                res = {3'b010, s, 7'h00};
            end else begin
                res = {3'b000, s, code[6:0]};
            end
        end
        return res;
    endfunction

    logic [1:0]  lane_cnt_q, lane_cnt_d;
    logic [31:0] stage_q, stage_d;
    logic [31:0] out_data_q, out_data_d;
    logic [3:0]  out_keep_q, out_keep_d;
    logic        out_valid_q, out_valid_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        nan_q, nan_d;
    logic        accept;
    logic        flush;
    logic [10:0] conv;
    logic [31:0] merged;
    logic [3:0]  keep_mask;

    assign bus.in_ready = !out_valid_q || bus.out_ready;

    always_comb begin
        conv        = convert(bus.in_data);
        accept      = bus.in_valid && bus.in_ready;
        flush       = accept && ((lane_cnt_q == 2'd3) || bus.in_last);
        merged      = stage_q;
        merged[{lane_cnt_q, 3'b000} +: 8] = conv[7:0];

        case (lane_cnt_q)
            2'd0:    keep_mask = 4'b0001;
            2'd1:    keep_mask = 4'b0011;
            2'd2:    keep_mask = 4'b0111;
            default: keep_mask = 4'b1111;
        endcase

        lane_cnt_d  = lane_cnt_q;
        stage_d     = stage_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // Staging is zeroed after every flush, so lanes above the counter are already 0.
        if (flush) begin
            out_data_d  = merged;
            out_keep_d  = keep_mask;
            out_valid_d = 1'b1;
            stage_d     = '0;
            lane_cnt_d  = 2'd0;
        end else if (accept) begin
            stage_d     = merged;
            lane_cnt_d  = lane_cnt_q + 2'd1;
        end

        ovf_d = (ovf_q && !clear_flags) || (accept && conv[10]);
        unf_d = (unf_q && !clear_flags) || (accept && conv[9]);
        nan_d = (nan_q && !clear_flags) || (accept && conv[8]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_cnt_q  <= '0;
            stage_q     <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            nan_q       <= 1'b0;
        end else begin
            lane_cnt_q  <= lane_cnt_d;
            stage_q     <= stage_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            nan_q       <= nan_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_keep  = out_keep_q;
    assign ovf_flag      = ovf_q;
    assign unf_flag      = unf_q;
    assign nan_flag      = nan_q;

endmodule

// File: tb/tb_bf16_to_fp8_packer.sv
// Scoreboard bench for bf16_to_fp8_packer: a real-valued nearest-E4M3 reference model feeds
// an expected-word queue that an independent monitor drains on every output handshake.
module tb_bf16_to_fp8_packer;
    logic clk = 1'b0;
    logic rst;
    logic clear_flags;
    logic ovf_flag, unf_flag, nan_flag;

    bf16_to_fp8_packer_if bus();

    bf16_to_fp8_packer dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clear_flags(clear_flags),
        .ovf_flag   (ovf_flag),
        .unf_flag   (unf_flag),
        .nan_flag   (nan_flag)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [35:0] exp_q[$];
    logic [7:0]  mdl_lanes[$];
    logic [2:0]  mdl_flags = 3'b000;
    int          ready_mode = 0;
    logic [31:0] last_word = '0;
    logic [3:0]  last_keep = '0;
    logic        stall_prev = 1'b0;
    logic [35:0] prev_word = '0;
    logic [35:0] exp_word;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    function automatic real p2(input int n);
        real r;
        r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    // Magnitude of E4M3 code c; code 120 (0x78) stands for 256, the first value past max finite.
    function automatic real e4m3_val(input int c);
        int ex;
        int mt;
        ex = c / 8;
        mt = c % 8;
        if (ex == 0) return real'(mt) * p2(-9);
        return real'(8 + mt) * p2(ex - 10);
    endfunction

    // Returns {ovf, unf, nan, byte}, chosen as the nearest code with ties to the even code.
    function automatic logic [10:0] ref_convert(input logic [15:0] v);
        int   e;
        int   m;
        logic s;
        real  x, d, bd;
        int   best;
        e = int'(v[14:7]);
        m = int'(v[6:0]);
        s = v[15];
        if (e == 255) return (m != 0) ? {3'b001, 8'h7C} : {3'b000, s, 7'h78};
        if (e == 0) return {3'b000, s, 7'h00};
        x = real'(128 + m) * p2(e - 134);
        best = 0;
        bd = x;
        for (int c = 1; c <= 120; c++) begin
            d = x - e4m3_val(c);
            if (d < 0.0) d = -d;
            if (d < bd || (d == bd && (c % 2) == 0)) begin
                best = c;
                bd = d;
            end
        end
`ifdef FP8_SAT_EN
        if (best == 120) return {3'b100, s, 7'h77};
`else
        if (best == 120) return {3'b100, s, 7'h78};
`endif
        if (best == 0) return {3'b010, s, 7'h00};
        return {3'b000, s, 7'(best)};
    endfunction

    function automatic void model_accept(input logic [15:0] v, input logic last, input logic clr);
        logic [10:0] r;
        logic [31:0] w;
        logic [3:0]  k;
        r = ref_convert(v);
        mdl_flags = (mdl_flags & ~{3{clr}}) | r[10:8];
        mdl_lanes.push_back(r[7:0]);
        if (mdl_lanes.size() == 4 || last) begin
            w = '0;
            k = '0;
            foreach (mdl_lanes[i]) begin
                w[8*i +: 8] = mdl_lanes[i];
                k[i] = 1'b1;
            end
            exp_q.push_back({k, w});
            mdl_lanes.delete();
        end
    endfunction

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = 1'($urandom);
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_hold", {27'd0, bus.out_valid, bus.out_keep, bus.out_data}, {27'd0, 1'b1, prev_word});
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_word: got keep=%h data=%h, required no output", bus.out_keep, bus.out_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("word", {28'd0, bus.out_keep, bus.out_data}, {28'd0, exp_word});
                end
                last_word = bus.out_data;
                last_keep = bus.out_keep;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_word  = {bus.out_keep, bus.out_data};
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] v, input logic last, input logic clr);
        bit acc;
        int unsigned n;
        acc = 1'b0;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        bus.in_last  = last;
        clear_flags  = clr;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            n++;
        end
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        clear_flags  = 1'b0;
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1", n);
        end else begin
            model_accept(v, last, clr);
            check("flags", {61'd0, ovf_flag, unf_flag, nan_flag}, {61'd0, mdl_flags});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state",
              {23'd0, bus.out_valid, bus.out_data, bus.out_keep, ovf_flag, unf_flag, nan_flag, bus.in_ready},
              64'd1);
        exp_q.delete();
        mdl_lanes.delete();
        mdl_flags = 3'b000;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_ready_mode(input int m);
        ready_mode = m;
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        @(posedge clk);
        #1;
        clear_flags = 1'b0;
        mdl_flags = 3'b000;
        check("flags_cleared", {61'd0, ovf_flag, unf_flag, nan_flag}, 64'd0);
    endtask

    logic [15:0] v;
    logic [15:0] nv[4];
    logic [10:0] rr;
    logic [31:0] nw;
    logic [31:0] held;
    int unsigned waited;

    initial begin
        rst          = 1'b1;
        clear_flags  = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.out_ready = 1'b1;
        do_reset();

        // Full word, no flags.
        send(16'h3F80, 1'b0, 1'b0);
        send(16'hC000, 1'b0, 1'b0);
        send(16'h4370, 1'b0, 1'b0);
        send(16'h3B00, 1'b0, 1'b0);
        settle();
        check("full_word", {32'd0, last_word}, 64'h0000_0000_0177_C038);
        check("full_keep", {60'd0, last_keep}, 64'hF);
        check("full_flags", {61'd0, ovf_flag, unf_flag, nan_flag}, 64'd0);

        // Partial flush on in_last.
        send(16'h3F80, 1'b0, 1'b0);
        send(16'hC000, 1'b1, 1'b0);
        settle();
        check("partial_word", {32'd0, last_word}, 64'h0000_C038);
        check("partial_keep", {60'd0, last_keep}, 64'h3);

        // Tie at 248 rounds up to 256.
`ifdef FP8_SAT_EN
        send(16'h4378, 1'b1, 1'b0);
        settle();
        check("ovf_lane", {56'd0, last_word[7:0]}, 64'h77);
`else
        send(16'h4378, 1'b1, 1'b0);
        settle();
        check("ovf_lane", {56'd0, last_word[7:0]}, 64'h78);
`endif
        check("ovf_flag", {63'd0, ovf_flag}, 64'd1);
        pulse_clear();

        // Underflow tie to even, then NaN.
        send(16'h3A80, 1'b0, 1'b0);
        check("unf_flag", {63'd0, unf_flag}, 64'd1);
        send(16'h7FC0, 1'b1, 1'b0);
        settle();
        check("unf_nan_word", {32'd0, last_word}, 64'h7C00);
        check("nan_flag", {63'd0, nan_flag}, 64'd1);
        pulse_clear();

        // Back-pressure: full word held while out_ready=0.
        set_ready_mode(1);
        send(16'h4000, 1'b0, 1'b0);
        send(16'hBF00, 1'b0, 1'b0);
        send(16'h4120, 1'b0, 1'b0);
        send(16'h3E80, 1'b0, 1'b0);
        @(negedge clk);
        held = bus.out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
            check("stall_data", {32'd0, bus.out_data}, {32'd0, held});
        end
        @(posedge clk);
        #1;
        set_ready_mode(0);
        @(negedge clk);
        @(negedge clk);
        check("drain_in_ready", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Reset mid-burst discards the partial word.
        send(16'h4100, 1'b0, 1'b0);
        send(16'h4200, 1'b0, 1'b0);
        do_reset();
        nv[0] = 16'h3C00; nv[1] = 16'hC080; nv[2] = 16'h4290; nv[3] = 16'h3A90;
        nw = '0;
        for (int i = 0; i < 4; i++) begin
            rr = ref_convert(nv[i]);
            nw[8*i +: 8] = rr[7:0];
            send(nv[i], 1'b0, 1'b0);
        end
        settle();
        check("post_reset_word", {32'd0, last_word}, {32'd0, nw});

        // Randomized traffic with random back-pressure.
        set_ready_mode(2);
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0:       v = 16'($urandom);
                1:       v = {1'($urandom), 8'hFF, 7'($urandom_range(0, 1) * $urandom_range(0, 127))};
                2:       v = {1'($urandom), 8'h00, 7'($urandom)};
                3:       v = {1'($urandom), 8'($urandom_range(100, 120)), 7'($urandom)};
                default: v = {1'($urandom), 8'($urandom_range(112, 136)), 7'($urandom)};
            endcase
            send(v, ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
        end
        send(16'h3F80, 1'b1, 1'b0);
        set_ready_mode(0);
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        #1;
        check("drain_complete", {32'd0, 32'(exp_q.size())}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
